// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller for the Alu block: decodes ALUOp/funct into Sel, holds
// registered operands on the Alu, waits out multiply latency and buffers the result.
module alu_exec_ctrl #(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_alu_op,
    input  logic [5:0]  i_funct,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic [31:0] o_alu_op1,
    output logic [31:0] o_alu_op2,
    output logic [3:0]  o_alu_sel,
    input  logic [31:0] i_alu_out,
    input  logic        i_alu_zflag,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_illegal,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MULW = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_MUL = 4'b0011;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // o_ready is high only in IDLE, o_valid only in DONE; both are registered.
    state_t     state;
    logic [3:0] cnt;
    logic       ill_q;
    logic [3:0] dec_sel;
    logic       dec_ill;

    assign dbg_state = state;

    always_comb begin
        dec_sel = SEL_ADD;
        dec_ill = 1'b0;
        case (i_alu_op)
            2'b00: dec_sel = SEL_ADD;
            2'b01: dec_sel = SEL_SUB;
            2'b11: dec_sel = SEL_OR;
            default: begin
                case (i_funct)
                    6'b100000: dec_sel = SEL_ADD;
                    6'b100010: dec_sel = SEL_SUB;
                    6'b100100: dec_sel = SEL_AND;
                    6'b100101: dec_sel = SEL_OR;
                    6'b101010: dec_sel = SEL_SLT;
                    6'b011000: dec_sel = SEL_MUL;
                    default: begin
                        dec_sel = SEL_ADD;
                        dec_ill = 1'b1;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ill_q     <= 1'b0;
            o_ready   <= 1'b1;
            o_valid   <= 1'b0;
            o_result  <= 32'd0;
            o_zero    <= 1'b0;
            o_illegal <= 1'b0;
            o_alu_op1 <= 32'd0;
            o_alu_op2 <= 32'd0;
            o_alu_sel <= SEL_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_alu_op1 <= i_op1;
                        o_alu_op2 <= i_op2;
                        o_alu_sel <= dec_sel;
                        ill_q     <= dec_ill;
                        o_ready   <= 1'b0;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (o_alu_sel != SEL_MUL || MUL_CNT == 4'd0) begin
                        o_result  <= i_alu_out;
                        o_zero    <= i_alu_zflag;
                        o_illegal <= ill_q;
                        o_valid   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt   <= MUL_CNT;
                        state <= MULW;
                    end
                end
                MULW: begin
                    // cnt==1 marks the edge MUL_LAT cycles after accept
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        o_result  <= i_alu_out;
                        o_zero    <= i_alu_zflag;
                        o_illegal <= ill_q;
                        o_valid   <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage controller sitting on the command side of the `Alu` block. It accepts a decoded operation (ALUOp class, funct field, two operands) over a valid/ready handshake and generates the 4-bit `Sel` code. It drives registered operands into `Alu` and waits the required number of cycles (extra cycles for multiply). It then captures `r_out`/`Zflag` into an output register held under a second valid/ready handshake toward writeback/branch logic.

## Interface
- `MUL_LAT`, default 3: cycles operands are held on the ALU before a multiply result is captured; legal range 1–15.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  controller can accept a request.
- `i_alu_op`  in  2  op class: 00 load/store/addi, 01 branch, 10 R-type, 11 ori.
- `i_funct`  in  6  R-type funct; ignored unless `i_alu_op`=10.
- `i_op1`, `i_op2`  in  32 each  operands.
- `o_alu_op1`, `o_alu_op2`  out  32 each  registered operands to `Alu` `i_op1`/`i_op2`.
- `o_alu_sel`  out  4  registered `Sel` to `Alu`.
- `i_alu_out`  in  32  `Alu` `r_out`.
- `i_alu_zflag`  in  1  `Alu` `Zflag`.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  consumer accepts result.
- `o_result`  out  32  captured result.
- `o_zero`  out  1  captured zero flag.
- `o_illegal`  out  1  unsupported funct was decoded for this result.

## Operation
- Sel decode at accept:
  - alu_op 00 → 0010 (ADD).
  - alu_op 01 → 0110 (SUB).
  - alu_op 11 → 0001 (OR).
  - alu_op 10, by funct:
    - 100000 → 0010
    - 100010 → 0110
    - 100100 → 0000
    - 100101 → 0001
    - 101010 → 0111
    - 011000 → 0011 (MUL)
    - any other funct → 0010, illegal bit set.
- FSM states IDLE, EXEC, MULW, DONE.
  - IDLE: `o_ready`=1. On `i_valid`: register operands, Sel and illegal bit; go to EXEC.
  - EXEC: if Sel≠0011, capture `i_alu_out`, `i_alu_zflag` and illegal bit into output registers; go to DONE. If Sel=0011, load counter with `MUL_LAT`-1.
    - If that value is 0, capture as the non-multiply path and go to DONE.
    - Otherwise go to MULW.
  - MULW: decrement counter; when counter reaches 1 on this edge, capture result and go to DONE.
  - DONE: `o_valid`=1. On `i_ready`, go to IDLE. Otherwise hold all outputs stable.
- `o_alu_op1`/`o_alu_op2`/`o_alu_sel` change only on accept. They are stable from EXEC through DONE.
- `o_zero` is the ALU flag as captured; no local recomputation.
- Multiply result is the low 32 bits, as produced by `Alu`.
- No new request is accepted in EXEC, MULW or DONE (`o_ready`=0). An `i_valid` in those states is ignored and must be held by the producer.

## Timing
- Reset (i_rst high at an edge):
  - State goes to IDLE.
  - `o_valid`, `o_result`, `o_zero`, `o_illegal`, `o_alu_op1`, `o_alu_op2` go to 0.
  - `o_alu_sel` goes to 0010.
  - Counter goes to 0.
  - `o_ready` reads 1 in the cycle after the reset edge.
- Latency from accept edge N to `o_valid`:
  - Non-multiply: high after edge N+1.
  - Multiply: high after edge N+`MUL_LAT`.
- Minimum initiation interval is 3 cycles non-multiply (accept, EXEC, DONE with `i_ready`=1), and `MUL_LAT`+2 for multiply.
- `i_ready` high while `o_valid`=0 has no effect.
- Reset during EXEC/MULW/DONE aborts the operation. The pending result is discarded and `o_valid` never pulses for it.
- `o_ready`, `o_valid` are pure functions of state (no combinational path from `i_valid`/`i_ready`).

## Test plan
- Reset, then alu_op=10 funct=100000 with op1=5, op2=7 → `o_alu_sel`=0010; after 1 cycle, `o_valid`=1, `o_result`=12, `o_zero`=0, `o_illegal`=0.
- alu_op=01, op1=op2=0x1234 → Sel 0110, `o_result`=0, `o_zero`=1.
- funct=011000, op1=6, op2=7, `MUL_LAT`=3 → `o_valid` rises exactly 3 cycles after accept with `o_result`=42. `o_ready`=0 throughout; a second `i_valid` in that window is not accepted.
- funct=111111, op1=1, op2=2 → Sel 0010, `o_result`=3, `o_illegal`=1.
- Backpressure: hold `i_ready`=0 for 5 cycles in DONE after an SLT with op1=3, op2=9. `o_result`=1 stays stable and `o_valid` stays high; `i_ready`=1 → IDLE next cycle.
- Assert `i_rst` during MULW → no `o_valid` pulse. All outputs at reset values, and `o_ready`=1 the cycle after reset.
